// File: rtl/window_3x3_gen.sv
// Raster pixel stream to 3x3 neighbourhood generator for the median filter stage.
// Latency: window for accepted pixel (R,C) appears the following cycle centred at (R-1,C-1).
// No backpressure: every accepted pixel is consumed; in_valid gaps simply stall all state.
//
// Ports:
//   clk, rst         : rising-edge clock, asynchronous active-high reset
//   in_valid/in_sof  : pixel strobe; sof (qualified by valid) forces the pixel to (0,0)
//   in_pixel         : raster-order pixel value
//   out_valid        : one-cycle pulse per interior window
//   out_win          : 3x3 window, slice [PIX_W*(3*i+j) +: PIX_W] = pixel (r-1+i, c-1+j)
//   out_row/out_col  : centre coordinates of out_win
//   frame_done       : pulses with the last window of a frame
module window_3x3_gen #(
    parameter int IMG_W = 100,
    parameter int IMG_H = 100,
    parameter int PIX_W = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    input  logic                     in_sof,
    input  logic [PIX_W-1:0]         in_pixel,
    output logic                     out_valid,
    output logic [9*PIX_W-1:0]       out_win,
    output logic [$clog2(IMG_H)-1:0] out_row,
    output logic [$clog2(IMG_W)-1:0] out_col,
    output logic                     frame_done
);

    localparam int COL_W = $clog2(IMG_W);
    localparam int ROW_W = $clog2(IMG_H);

    localparam logic [COL_W-1:0] LAST_COL = COL_W'(IMG_W - 1);
    localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(IMG_H - 1);

    localparam logic [0:0] ST_FILL   = 1'b0;
    localparam logic [0:0] ST_STREAM = 1'b1;

    logic [COL_W-1:0]   r_col;
    logic [ROW_W-1:0]   r_row;
    logic [0:0]         r_state;

    // Line buffers: lb0 = previous row, lb1 = row before that. Not reset;
    // rows 0 and 1 of every frame refill them before any window is emitted.
    logic [PIX_W-1:0]   r_lb0 [IMG_W];
    logic [PIX_W-1:0]   r_lb1 [IMG_W];

    // Two most recent window columns, packed top/mid/bottom from LSB up.
    logic [3*PIX_W-1:0] r_win_c0;
    logic [3*PIX_W-1:0] r_win_c1;

    logic [COL_W-1:0]   w_col;
    logic [ROW_W-1:0]   w_row;
    logic [PIX_W-1:0]   w_lb0_q;
    logic [PIX_W-1:0]   w_lb1_q;
    logic [3*PIX_W-1:0] w_win_c2;
    logic [9*PIX_W-1:0] w_win;
    logic               w_last_pix;
    logic               w_emit;

    // A start-of-frame pixel is position (0,0) regardless of where the counters are.
    assign w_col = in_sof ? '0 : r_col;
    assign w_row = in_sof ? '0 : r_row;

    // Read-before-write: these return the values stored before this pixel's write.
    assign w_lb0_q  = r_lb0[w_col];
    assign w_lb1_q  = r_lb1[w_col];
    assign w_win_c2 = {in_pixel, w_lb0_q, w_lb1_q};

    assign w_last_pix = (w_row == LAST_ROW) && (w_col == LAST_COL);

    // STREAM covers rows >= 2 (col 0 of row 2 is still FILL, but col < 2 never
    // emits). The col >= 2 gate keeps columns of the previous row out of the window.
    assign w_emit = in_valid && !in_sof && (r_state == ST_STREAM) && (w_col >= COL_W'(2));

    always_comb begin
        w_win = '0;
        for (int i = 0; i < 3; i++) begin
            w_win[PIX_W*(3*i+0) +: PIX_W] = r_win_c0[PIX_W*i +: PIX_W];
            w_win[PIX_W*(3*i+1) +: PIX_W] = r_win_c1[PIX_W*i +: PIX_W];
            w_win[PIX_W*(3*i+2) +: PIX_W] = w_win_c2[PIX_W*i +: PIX_W];
        end
    end

    always_ff @(posedge clk) begin
        if (in_valid) begin
            r_lb1[w_col] <= w_lb0_q;
            r_lb0[w_col] <= in_pixel;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_col      <= '0;
            r_row      <= '0;
            r_state    <= ST_FILL;
            r_win_c0   <= '0;
            r_win_c1   <= '0;
            out_valid  <= 1'b0;
            frame_done <= 1'b0;
            out_win    <= '0;
            out_row    <= '0;
            out_col    <= '0;
        end else begin
            out_valid  <= w_emit;
            frame_done <= w_emit && w_last_pix;
            if (in_valid) begin
                r_win_c0 <= r_win_c1;
                r_win_c1 <= w_win_c2;

                if (w_col == LAST_COL) begin
                    r_col <= '0;
                    r_row <= (w_row == LAST_ROW) ? '0 : w_row + 1'b1;
                end else begin
                    r_col <= w_col + 1'b1;
                    r_row <= w_row;
                end

                if (in_sof || w_last_pix) begin
                    r_state <= ST_FILL;
                end else if ((w_row == ROW_W'(2)) && (w_col == '0)) begin
                    r_state <= ST_STREAM;
                end

                if (w_emit) begin
                    out_win <= w_win;
                    out_row <= w_row - 1'b1;
                    out_col <= w_col - 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_window_3x3_gen.sv
module tb_window_3x3_gen;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_sof = 1'b0;
    logic [7:0]  in_pixel = '0;
    logic        out_valid;
    logic [71:0] out_win;
    logic [6:0]  out_row;
    logic [6:0]  out_col;
    logic        frame_done;

    logic        s_valid = 1'b0;
    logic        s_sof = 1'b0;
    logic [7:0]  s_pix = '0;
    logic        s_out_valid;
    logic [71:0] s_out_win;
    logic [1:0]  s_out_row;
    logic [1:0]  s_out_col;
    logic        s_fd;

    always #5 clk = ~clk;

    window_3x3_gen #(.IMG_W(100), .IMG_H(100), .PIX_W(8)) u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_sof(in_sof), .in_pixel(in_pixel),
        .out_valid(out_valid), .out_win(out_win), .out_row(out_row), .out_col(out_col),
        .frame_done(frame_done)
    );

    window_3x3_gen #(.IMG_W(4), .IMG_H(3), .PIX_W(8)) u_small (
        .clk(clk), .rst(rst), .in_valid(s_valid), .in_sof(s_sof), .in_pixel(s_pix),
        .out_valid(s_out_valid), .out_win(s_out_win), .out_row(s_out_row), .out_col(s_out_col),
        .frame_done(s_fd)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [71:0] act, input logic [71:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // Reference model: the current frame as a 2-D image plus raster position.
    logic [7:0]  img [100][100];
    int          m_row = 0, m_col = 0;
    logic        exp_vld = 0, exp_fd = 0;
    logic [71:0] exp_win = '0;
    logic [6:0]  exp_row = '0, exp_col = '0;

    // Per-scenario bookkeeping of observed windows.
    int          win_cnt, fd_cnt, n_acc, first_acc;
    bit          got_first;
    logic [6:0]  first_row, first_col, last_row, last_col;
    logic [71:0] first_win, last_win;
    logic [71:0] ref_seq [$];
    bit          rec_seq = 0, cmp_seq = 0;

    function automatic logic [7:0] pix(input int r, input int c);
        return 8'((r * 100 + c) % 256);
    endfunction

    task automatic model_reset();
        m_row = 0; m_col = 0;
        exp_vld = 0; exp_fd = 0;
        exp_win = '0; exp_row = '0; exp_col = '0;
    endtask

    task automatic model_step(input logic v, input logic s, input logic [7:0] p);
        exp_vld = 0;
        exp_fd  = 0;
        if (v) begin
            if (s) begin m_row = 0; m_col = 0; end
            img[m_row][m_col] = p;
            if (m_row >= 2 && m_col >= 2) begin
                exp_vld = 1;
                exp_row = 7'(m_row - 1);
                exp_col = 7'(m_col - 1);
                for (int i = 0; i < 3; i++)
                    for (int j = 0; j < 3; j++)
                        exp_win[8*(3*i+j) +: 8] = img[m_row-2+i][m_col-2+j];
                exp_fd = (m_row == 99 && m_col == 99);
            end
            m_col++;
            if (m_col == 100) begin
                m_col = 0;
                m_row = (m_row == 99) ? 0 : m_row + 1;
            end
        end
    endtask

    task automatic compare();
        chk("vld", {71'd0, out_valid}, {71'd0, exp_vld});
        chk("frame_done", {71'd0, frame_done}, {71'd0, exp_fd});
        chk("win", out_win, exp_win);
        chk("row", {65'd0, out_row}, {65'd0, exp_row});
        chk("col", {65'd0, out_col}, {65'd0, exp_col});
        if (out_valid) begin
            win_cnt++;
            if (!got_first) begin
                got_first = 1; first_acc = n_acc;
                first_row = out_row; first_col = out_col; first_win = out_win;
            end
            last_row = out_row; last_col = out_col; last_win = out_win;
            if (rec_seq) ref_seq.push_back(out_win);
            if (cmp_seq) begin
                if (ref_seq.size() == 0) chk("seq_len", 72'd1, 72'd0);
                else chk("seq_match", out_win, ref_seq.pop_front());
            end
        end
        if (frame_done) fd_cnt++;
    endtask

    task automatic drive(input logic v, input logic s, input logic [7:0] p);
        in_valid = v; in_sof = s; in_pixel = p;
        @(posedge clk);
        if (v) n_acc++;
        model_step(v, s, p);
        @(negedge clk);
        compare();
    endtask

    task automatic send_pixels(input int n, input int gap_pct, input bit sof0);
        for (int k = 0; k < n; k++) begin
            while ($urandom_range(99) < gap_pct)
                drive(1'b0, 1'($urandom_range(1)), 8'($urandom_range(255)));
            drive(1'b1, sof0 && (k == 0), pix(k / 100, k % 100));
        end
        drive(1'b0, 1'b0, 8'h00);
    endtask

    task automatic start_scn();
        win_cnt = 0; fd_cnt = 0; n_acc = 0; first_acc = 0; got_first = 0;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_vld"}, {71'd0, out_valid}, 72'd0);
        chk({tag, "_fd"}, {71'd0, frame_done}, 72'd0);
        chk({tag, "_win"}, out_win, 72'd0);
        chk({tag, "_rowcol"}, {58'd0, out_row, out_col}, 72'd0);
        chk({tag, "_s_vld"}, {71'd0, s_out_valid}, 72'd0);
        chk({tag, "_s_win"}, s_out_win, 72'd0);
    endtask

    task automatic check_frame(input string tag);
        logic [71:0] w;
        chk({tag, "_count"}, 72'(win_cnt), 72'd9604);
        chk({tag, "_fd_count"}, 72'(fd_cnt), 72'd1);
        chk({tag, "_first_row"}, {65'd0, first_row}, 72'd1);
        chk({tag, "_first_col"}, {65'd0, first_col}, 72'd1);
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
                w[8*(3*i+j) +: 8] = pix(i, j);
        chk({tag, "_first_win"}, first_win, w);
        chk({tag, "_last_row"}, {65'd0, last_row}, 72'd98);
        chk({tag, "_last_col"}, {65'd0, last_col}, 72'd98);
        chk({tag, "_last_tl"}, {64'd0, last_win[7:0]}, 72'd69);
        chk({tag, "_last_br"}, {64'd0, last_win[71:64]}, 72'd15);
    endtask

    initial begin
        logic [71:0] sw;
        model_reset();
        #1;
        check_reset_outputs("por");
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // 1: continuous full frame
        start_scn(); rec_seq = 1;
        send_pixels(10000, 0, 1'b1);
        rec_seq = 0;
        check_frame("s1");
        chk("s1_first_after_pix", 72'(first_acc), 72'd203);

        // 2: same frame with ~30% idle cycles
        start_scn(); cmp_seq = 1;
        send_pixels(10000, 30, 1'b1);
        cmp_seq = 0;
        check_frame("s2");
        chk("s2_seq_left", 72'(ref_seq.size()), 72'd0);

        // 4: reset mid-frame, then a frame without sof
        send_pixels(5000, 0, 1'b1);
        rst = 1'b1;
        in_valid = 1'b0;
        model_reset();
        #1;
        check_reset_outputs("midrst");
        repeat (2) @(negedge clk);
        check_reset_outputs("midrst_hold");
        rst = 1'b0;
        start_scn();
        send_pixels(10000, 0, 1'b0);
        check_frame("s4");

        // 5: sof abandons a partial frame
        start_scn();
        send_pixels(3000, 0, 1'b1);
        chk("s5_abort_fd", 72'(fd_cnt), 72'd0);
        start_scn();
        send_pixels(10000, 10, 1'b1);
        check_frame("s5");

        // 6: 4x3 image, pixels 0..11
        for (int k = 0; k < 13; k++) begin
            s_valid = (k < 12);
            s_sof = (k == 0);
            s_pix = 8'(k);
            @(posedge clk);
            @(negedge clk);
            chk("small_vld", {71'd0, s_out_valid}, {71'd0, (k == 10 || k == 11)});
            chk("small_fd", {71'd0, s_fd}, {71'd0, (k == 11)});
            if (k == 10 || k == 11) begin
                for (int i = 0; i < 3; i++)
                    for (int j = 0; j < 3; j++)
                        sw[8*(3*i+j) +: 8] = 8'(i * 4 + (k - 8) - 2 + j);
                chk("small_win", s_out_win, sw);
                chk("small_row", {70'd0, s_out_row}, 72'd1);
                chk("small_col", {70'd0, s_out_col}, 72'(k - 9));
            end
        end
        s_valid = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/window_3x3_gen.md
Name: window_3x3_gen

Overview:
Raster-order pixel-stream to 3x3 neighbourhood generator. It sits directly upstream of the median filter stage. Two internal line buffers plus a 3x3 shift window present each interior pixel's full neighbourhood in one cycle. Border pixels (row/col 0 and last) produce no window; the downstream filter passes them through unchanged.

Parameters:
IMG_W, 100, image width in pixels (>=3)
IMG_H, 100, image height in pixels (>=3)
PIX_W, 8, bits per pixel

Ports:
clk  in  1  system clock, all state on rising edge
rst  in  1  asynchronous, active-high reset
in_valid  in  1  in_pixel valid this cycle; no backpressure, gaps allowed
in_sof  in  1  start of frame; qualified by in_valid, forces this pixel to (row 0, col 0)
in_pixel  in  PIX_W  pixel value, raster order (row-major, col 0 first)
out_valid  out  1  out_win/out_row/out_col valid, one-cycle pulse per window
out_win  out  9*PIX_W  window; slice [PIX_W*(3*i+j) +: PIX_W] = pixel (r-1+i, c-1+j), i,j in 0..2
out_row  out  $clog2(IMG_H)  centre row r, range 1..IMG_H-2
out_col  out  $clog2(IMG_W)  centre col c, range 1..IMG_W-2
frame_done  out  1  one-cycle pulse coincident with the last window of a frame

Behaviour:
- Reset (async assert, sync release): out_valid=0, frame_done=0, out_win=0, out_row=0, out_col=0, col/row counters=0, state=FILL. Line buffer RAM contents are not reset and must not be observable before refill.
- Counters col (0..IMG_W-1) and row (0..IMG_H-1) advance only on accepted pixels (in_valid=1). col wraps to 0 and increments row. After (IMG_H-1, IMG_W-1), both wrap to 0.
- Line buffers: lb0 holds row r-1 and lb1 holds row r-2, both indexed by col. On each accepted pixel, read lb0[col] and lb1[col], write lb1[col]<=lb0[col] and lb0[col]<=in_pixel. The read returns the old value (read-before-write).
- Window shift register: each accepted pixel shifts the 3 columns left. The new right column is {lb1[col], lb0[col], in_pixel} for rows top, mid, bottom. Columns of a previous row must never appear in a window; validity gating by col>=2 guarantees this.
- States:
  - FILL: rows 0..1.
  - STREAM: rows 2..IMG_H-1.
  - FILL -> STREAM when the first pixel of row 2 is accepted.
  - STREAM -> FILL on acceptance of the last pixel of the frame.
- Latency: when pixel (R,C) is accepted in STREAM with C>=2, the next cycle drives out_valid=1, out_row=R-1, out_col=C-1. Exactly one window per accepted pixel satisfying R>=2 and C>=2, giving (IMG_H-2)*(IMG_W-2) windows per frame (9604 at defaults).
- frame_done=1 in the same cycle as the window centred at (IMG_H-2, IMG_W-2); 0 otherwise.
- out_win/out_row/out_col hold their last value when out_valid=0.
- in_sof with in_valid: the pixel is treated as (0,0) and state goes to FILL. Any partial frame in progress is abandoned, with no frame_done and no further windows from it. in_sof without in_valid is ignored. in_sof on a pixel that is already (0,0) has no extra effect.
- in_valid=0: no state change. out_valid=0 the following cycle.
- Reset mid-frame: all outputs drop immediately (async). The next accepted pixel is (0,0).

Test Plan:
1. 100x100 frame, pixel(r,c)=(r*100+c) mod 256, in_valid continuous:
   - exactly 9604 out_valid pulses;
   - first pulse is 1 cycle after the 203rd pixel, with out_row=1, out_col=1;
   - out_win bytes low->high = 0,1,2,100,101,102,200,201,202.
2. Same frame with random in_valid gaps (~30% idle) -> identical window sequence and values to scenario 1; out_valid never follows an idle input cycle.
3. Last window of scenario 1 -> out_row=98, out_col=98, frame_done=1 in the same cycle; top-left byte=69, bottom-right byte=15. frame_done pulses exactly once per frame.
4. Assert rst after 5000 pixels, release, then send a full frame -> outputs 0 during reset; 9604 windows, the first at (1,1) with scenario-1 values, with no stale data.
5. Assert in_sof at pixel 3000 of a frame, then stream a full frame from there -> no frame_done for the aborted frame; 9604 windows, the first at (1,1).
6. Instantiate IMG_W=4, IMG_H=3, pixels 0..11 -> exactly 2 windows:
   - (1,1) = 0,1,2,4,5,6,8,9,10;
   - (1,2) = 1,2,3,5,6,7,9,10,11, with frame_done=1.
